// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), synchronous flush and starvation counter.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no valid item held
// ST_FULL  | main entry valid, skid entry empty
// ST_SKID  | main and skid entries valid, upstream stalled
module pipe_stage_reg #(
  parameter int DATA_W    = 101,
  parameter int CTRL_W    = 5,
  parameter int SKID      = 1,
  parameter int ZERO_DATA = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              push;
  logic              pop;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  // A bubble must never carry write enables downstream.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              ready_q;

      // in_ready comes straight from a flop so upstream sees no combinational path.
      assign in_ready = ready_q;

      // Three-state stage control with skid entry; flush drops everything, push included.
      always_ff @(posedge clk) begin
        if (!reset) begin
          state     <= ST_EMPTY;
          main_data <= '0;
          main_ctrl <= '0;
          skid_data <= '0;
          skid_ctrl <= '0;
          ready_q   <= 1'b1;
        end else if (flush) begin
          state     <= ST_EMPTY;
          main_ctrl <= '0;
          skid_ctrl <= '0;
          ready_q   <= 1'b1;
          if (ZERO_DATA != 0) begin
            main_data <= '0;
            skid_data <= '0;
          end
        end else begin
          case (state)
            ST_EMPTY: begin
              if (push) begin
                state     <= ST_FULL;
                main_data <= in_data;
                main_ctrl <= in_ctrl;
              end
            end
            ST_FULL: begin
              if (push && pop) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
              end else if (push) begin
                state     <= ST_SKID;
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                ready_q   <= 1'b0;
              end else if (pop) begin
                state     <= ST_EMPTY;
                main_ctrl <= '0;
                if (ZERO_DATA != 0) main_data <= '0;
              end
            end
            ST_SKID: begin
              if (pop) begin
                state     <= ST_FULL;
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                skid_ctrl <= '0;
                ready_q   <= 1'b1;
                if (ZERO_DATA != 0) skid_data <= '0;
              end
            end
            default: begin
              state     <= ST_EMPTY;
              main_ctrl <= '0;
              skid_ctrl <= '0;
              ready_q   <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      // Single entry: can accept when empty or when the head leaves this cycle.
      assign in_ready = ~out_valid | out_ready;

      // Two-state stage control; a push always lands in main (with or without a pop).
      always_ff @(posedge clk) begin
        if (!reset) begin
          state     <= ST_EMPTY;
          main_data <= '0;
          main_ctrl <= '0;
        end else if (flush) begin
          state     <= ST_EMPTY;
          main_ctrl <= '0;
          if (ZERO_DATA != 0) main_data <= '0;
        end else if (push) begin
          state     <= ST_FULL;
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else if (pop) begin
          state     <= ST_EMPTY;
          main_ctrl <= '0;
          if (ZERO_DATA != 0) main_data <= '0;
        end
      end
    end
  endgenerate

  // Starvation counter: downstream ready but nothing to give; saturates, reset-only clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the pipeline register set, replacing fixed-field stage registers (EX/MEM style).
- Carries an opaque data bundle and a control bundle between stages using a valid/ready handshake.
- Provides an optional 2-entry skid buffer so `in_ready` is fully registered.
- Supports a synchronous flush that inserts a bubble, and a saturating starvation counter.

Parameters:
- DATA_W, 101: width of data bundle (e.g. alu_out 32 + rt 32 + write_addr 5 + pc_next 32).
- CTRL_W, 5: width of control bundle (MemRead, MemWrite, MemtoReg[1:0], RegWrite); forced to zero when not valid.
- SKID, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- ZERO_DATA, 1: 1 = data fields cleared on flush/pop; 0 = data fields hold their last value.
- CNT_W, 8: width of the bubble counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream holds a valid item.
- in_ready  output  1  stage can accept an item this cycle.
- in_data  input  DATA_W  upstream data bundle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- flush  input  1  kill all stage contents (branch/exception).
- out_valid  output  1  stage holds a valid item.
- out_ready  input  1  downstream accepts an item this cycle.
- out_data  output  DATA_W  data of the head entry.
- out_ctrl  output  CTRL_W  control of the head entry; 0 when out_valid=0.
- bubble_cnt  output  CNT_W  count of cycles downstream was starved.

Behaviour:
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Upstream must hold in_data/in_ctrl stable while in_valid=1 and in_ready=0.
- Reset (reset=0 at a clk edge):
  - State EMPTY; main and skid entries invalid.
  - Data and ctrl registers = 0; bubble_cnt = 0.
  - Consequently out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=1 on the first cycle after reset.
  - Reset overrides flush and every handshake, including mid-transfer.
- Latency: 1 cycle. An item pushed at edge N is presented on out_* after edge N; there is no combinational in->out path.
- State machine for SKID=1 (states EMPTY, FULL, SKID); in_ready = (state != SKID), driven from a register:
  - EMPTY: push -> FULL (main <= in).
  - FULL, push & pop -> FULL (main <= in).
  - FULL, push only -> SKID (skid <= in; main holds).
  - FULL, pop only -> EMPTY.
  - SKID: no push possible; pop -> FULL (main <= skid, skid cleared); otherwise hold.
- State machine for SKID=0 (states EMPTY, FULL only):
  - in_ready = ~out_valid | out_ready (combinational).
  - FULL with push & pop -> FULL (main <= in).
  - The skid register is not instantiated.
- Ordering: strictly FIFO; skid contents are never overtaken by a new input.
- out_ctrl = valid ? ctrl_q : 0, which guarantees a bubble never asserts memory or register writes.
- Data clearing when ZERO_DATA=1: data registers clear to 0 on any transition into EMPTY.
- Flush (flush=1 at an edge, reset=1):
  - Next state EMPTY; all ctrl registers = 0; data registers = 0 if ZERO_DATA=1, else hold.
  - A push in the same cycle is discarded (item dropped, upstream sees the handshake complete).
  - A pop in the same cycle completes normally: downstream consumes the head item.
  - Flush while in EMPTY is a no-op apart from clearing.
- bubble_cnt:
  - Increments by 1 each cycle with out_ready=1 and out_valid=0, including flush-induced empties.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- No X on any output after the first reset edge.

Test Plan:
- Reset hold: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1, bubble_cnt=0 after release.
- Streaming: SKID=1, out_ready=1, push 0x11..0x14 back-to-back -> out_data 0x11..0x14 on consecutive cycles, 1-cycle latency, in_ready never drops.
- Backpressure:
  - Stimulus: out_ready=0, push A=0xAA then B=0xBB.
  - Required: state SKID, in_ready=0, C held off.
  - Release: out_ready=1 -> outputs A, B, C in order; none lost or duplicated.
- Flush in SKID:
  - Stimulus: fill A, B, then flush=1 with in_valid=1 (item C).
  - Required next cycle: out_valid=0, out_ctrl=0, out_data=0, in_ready=1; C never appears.
- Bubble counter: CNT_W=3, out_ready=1, in_valid=0 for 10 cycles -> bubble_cnt counts 1..7 and stays at 7.
- SKID=0 variant: out_ready toggles 1,0,1 with continuous in_valid -> in_ready follows ~out_valid|out_ready combinationally; sequence preserved.
